// File: rtl/psum_accum_unit.sv
// psum_accum_unit
// Multi-filter multiply/accumulate engine. Each accepted beat multiplies
// if_data by filt_data (stage S1), then adds the product into one of FILT_NUM
// partial-sum entries (stage S2). The base of the addition is either the
// stored entry or, on the first beat of a window, a seed (psum_in or zero).
// The last beat of a window publishes its result to the output buffer under
// an outbuf_full back-pressure handshake that freezes the whole pipeline.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   clr                 synchronous clear of entries, pipeline, output, flags
//   in_valid/in_ready   operand beat handshake (in_ready = ~stall_pipeline)
//   if_data, filt_data  unsigned operands
//   entry_addr          target partial-sum entry
//   first, last         window delimiters
//   seed_psum, psum_in  seed selection / external partial sum (with first)
//   outbuf_full         output buffer back-pressure
//   outbuf_write        write strobe to the output buffer
//   module_outval       result data, out_addr its entry index
//   psum_done           one-cycle pulse after a completed write
//   stall_pipeline      pipeline frozen
//   overflow            sticky wrap/clamp flag
module psum_accum_unit #(
    parameter int IF_WIDTH   = 8,
    parameter int FILT_WIDTH = 8,
    parameter int PSUM_WIDTH = 20,
    parameter int FILT_NUM   = 4,
    parameter int ADDR_LEN   = 2,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IF_WIDTH-1:0]   if_data,
    input  logic [FILT_WIDTH-1:0] filt_data,
    input  logic [ADDR_LEN-1:0]   entry_addr,
    input  logic                  first,
    input  logic                  last,
    input  logic                  seed_psum,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    input  logic                  outbuf_full,
    output logic                  outbuf_write,
    output logic [PSUM_WIDTH-1:0] module_outval,
    output logic [ADDR_LEN-1:0]   out_addr,
    output logic                  psum_done,
    output logic                  stall_pipeline,
    output logic                  overflow
);

    localparam int PROD_WIDTH = IF_WIDTH + FILT_WIDTH;

    logic [PSUM_WIDTH-1:0] entries [FILT_NUM];

    // S1 stage registers
    logic                  s1_valid;
    logic [PSUM_WIDTH-1:0] s1_prod;
    logic [PSUM_WIDTH-1:0] s1_seed;
    logic [ADDR_LEN-1:0]   s1_addr;
    logic                  s1_first;
    logic                  s1_last;

    logic                  out_valid;

    logic                  accept;
    logic [PROD_WIDTH-1:0] prod;
    logic [PSUM_WIDTH-1:0] stored;
    logic                  addr_ok;
    logic [PSUM_WIDTH-1:0] base;
    logic [PSUM_WIDTH:0]   sum_ext;
    logic                  carry;
    logic [PSUM_WIDTH-1:0] result;
    logic                  s2_fire;

    assign stall_pipeline = out_valid & outbuf_full;
    assign in_ready       = ~stall_pipeline;
    assign outbuf_write   = out_valid & ~outbuf_full;
    assign accept         = in_valid & in_ready;
    assign prod           = PROD_WIDTH'(if_data) * PROD_WIDTH'(filt_data);

    // Look up the entry addressed by the S1 beat; an address beyond FILT_NUM
    // never matches, which makes the beat fall through S2 as a no-op.
    always_comb begin
        stored  = '0;
        addr_ok = 1'b0;
        for (int i = 0; i < FILT_NUM; i++) begin
            stored  = (s1_addr == ADDR_LEN'(i)) ? entries[i] : stored;
            addr_ok = addr_ok | (s1_addr == ADDR_LEN'(i));
        end
    end

    // S2 arithmetic: one extra bit catches the carry out of the accumulation.
    always_comb begin
        base    = s1_first ? s1_seed : stored;
        sum_ext = {1'b0, base} + {1'b0, s1_prod};
        carry   = sum_ext[PSUM_WIDTH];
        if (carry && (SATURATE != 0)) begin
            result = '1;
        end else begin
            result = sum_ext[PSUM_WIDTH-1:0];
        end
        s2_fire = s1_valid & addr_ok;
    end

    // S1: capture product and beat attributes; frozen while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_seed  <= '0;
            s1_addr  <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_seed  <= '0;
            s1_addr  <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!stall_pipeline) begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod  <= PSUM_WIDTH'(prod);
                s1_seed  <= seed_psum ? psum_in : '0;
                s1_addr  <= entry_addr;
                s1_first <= first;
                s1_last  <= last;
            end
        end
    end

    // S2: write back the accumulated value and record any overflow. The write
    // lands one edge before the next beat's S2, so no bypass is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FILT_NUM; i++) begin
                entries[i] <= '0;
            end
            overflow <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < FILT_NUM; i++) begin
                entries[i] <= '0;
            end
            overflow <= 1'b0;
        end else if (!stall_pipeline && s2_fire) begin
            for (int i = 0; i < FILT_NUM; i++) begin
                if (s1_addr == ADDR_LEN'(i)) begin
                    entries[i] <= result;
                end
            end
            if (carry) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output register and write handshake; a new last beat may reload the
    // register on the same edge the previous result is written out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            module_outval <= '0;
            out_addr      <= '0;
            psum_done     <= 1'b0;
        end else if (clr) begin
            out_valid     <= 1'b0;
            module_outval <= '0;
            out_addr      <= '0;
            psum_done     <= 1'b0;
        end else if (stall_pipeline) begin
            psum_done     <= 1'b0;
        end else begin
            psum_done <= outbuf_write;
            if (s2_fire && s1_last) begin
                out_valid     <= 1'b1;
                module_outval <= result;
                out_addr      <= s1_addr;
            end else if (outbuf_write) begin
                out_valid     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum_unit.sv
module tb_psum_accum_unit;

    localparam int PW = 16;
    localparam int FN = 3;
    localparam int AL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    if_data = 8'd0;
    logic [7:0]    filt_data = 8'd0;
    logic [AL-1:0] entry_addr = 2'd0;
    logic          first = 1'b0;
    logic          last = 1'b0;
    logic          seed_psum = 1'b0;
    logic [PW-1:0] psum_in = 16'd0;
    logic          outbuf_full = 1'b0;

    logic          in_ready_w, outbuf_write_w, psum_done_w, stall_w, overflow_w;
    logic [PW-1:0] module_outval_w;
    logic [AL-1:0] out_addr_w;
    logic          in_ready_s, outbuf_write_s, psum_done_s, stall_s, overflow_s;
    logic [PW-1:0] module_outval_s;
    logic [AL-1:0] out_addr_s;

    psum_accum_unit #(.IF_WIDTH(8), .FILT_WIDTH(8), .PSUM_WIDTH(PW), .FILT_NUM(FN),
                      .ADDR_LEN(AL), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
        .if_data(if_data), .filt_data(filt_data), .entry_addr(entry_addr),
        .first(first), .last(last), .seed_psum(seed_psum), .psum_in(psum_in),
        .outbuf_full(outbuf_full), .outbuf_write(outbuf_write_w),
        .module_outval(module_outval_w), .out_addr(out_addr_w), .psum_done(psum_done_w),
        .stall_pipeline(stall_w), .overflow(overflow_w));

    psum_accum_unit #(.IF_WIDTH(8), .FILT_WIDTH(8), .PSUM_WIDTH(PW), .FILT_NUM(FN),
                      .ADDR_LEN(AL), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
        .if_data(if_data), .filt_data(filt_data), .entry_addr(entry_addr),
        .first(first), .last(last), .seed_psum(seed_psum), .psum_in(psum_in),
        .outbuf_full(outbuf_full), .outbuf_write(outbuf_write_s),
        .module_outval(module_outval_s), .out_addr(out_addr_s), .psum_done(psum_done_s),
        .stall_pipeline(stall_s), .overflow(overflow_s));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Results are computed at acceptance time (entries evolve in beat order);
    // a one-slot delay carries each result until it reaches the output.
    int  ent [2][FN];
    bit  sv, slast, sdis;
    int  saddr;
    int  sres [2];
    bit  sovf [2];
    bit  ov;
    int  val [2];
    int  oaddr;
    bit  done;
    bit  ovf [2];
    int  log_w[$];
    int  log_s[$];
    int  log_a[$];
    int  rst_pulses = 0;
    int  rst_seen = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < FN; e++) ent[k][e] = 0;
            val[k] = 0;
            ovf[k] = 1'b0;
            sovf[k] = 1'b0;
            sres[k] = 0;
        end
        sv = 1'b0; slast = 1'b0; sdis = 1'b0; saddr = 0;
        ov = 1'b0; oaddr = 0; done = 1'b0;
    endtask

    task automatic check_dut(input string p, input int k, input logic st, input logic rdy,
                             input logic wr, input logic dn, input logic of,
                             input logic [PW-1:0] v, input logic [AL-1:0] a,
                             input bit stall_m, input bit wr_m);
        chk({p, " stall_pipeline"}, 32'(st), 32'(stall_m));
        chk({p, " in_ready"}, 32'(rdy), 32'(!stall_m));
        chk({p, " outbuf_write"}, 32'(wr), 32'(wr_m));
        chk({p, " psum_done"}, 32'(dn), 32'(done));
        chk({p, " overflow"}, 32'(of), 32'(ovf[k]));
        if (ov) begin
            chk({p, " module_outval"}, 32'(v), 32'(val[k]));
            chk({p, " out_addr"}, 32'(a), 32'(oaddr));
        end
    endtask

    // Compare process: check every cycle on the falling edge, then step the model.
    initial begin
        bit stall_m, wr_m, nov;
        int base, s;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst || rst_pulses != rst_seen) begin
                model_reset();
                rst_seen = rst_pulses;
            end
            stall_m = ov && outbuf_full;
            wr_m = ov && !outbuf_full;
            check_dut("wrap", 0, stall_w, in_ready_w, outbuf_write_w, psum_done_w, overflow_w,
                      module_outval_w, out_addr_w, stall_m, wr_m);
            check_dut("sat", 1, stall_s, in_ready_s, outbuf_write_s, psum_done_s, overflow_s,
                      module_outval_s, out_addr_s, stall_m, wr_m);
            if (outbuf_write_w) begin
                log_w.push_back(int'(module_outval_w));
                log_a.push_back(int'(out_addr_w));
            end
            if (outbuf_write_s) log_s.push_back(int'(module_outval_s));
            if (!rst) begin
                if (clr) begin
                    model_reset();
                end else if (!stall_m) begin
                    done = wr_m;
                    nov = ov && !wr_m;
                    if (sv && !sdis) begin
                        for (int k = 0; k < 2; k++) ovf[k] = ovf[k] | sovf[k];
                        if (slast) begin
                            nov = 1'b1;
                            for (int k = 0; k < 2; k++) val[k] = sres[k];
                            oaddr = saddr;
                        end
                    end
                    ov = nov;
                    sv = in_valid;
                    if (in_valid) begin
                        saddr = int'(entry_addr);
                        sdis = saddr >= FN;
                        slast = last;
                        for (int k = 0; k < 2; k++) begin
                            if (first) base = seed_psum ? int'(psum_in) : 0;
                            else base = sdis ? 0 : ent[k][saddr];
                            s = base + int'(if_data) * int'(filt_data);
                            sovf[k] = s > 65535;
                            sres[k] = (s > 65535) ? ((k == 1) ? 65535 : s - 65536) : s;
                            if (!sdis) ent[k][saddr] = sres[k];
                        end
                    end
                end else begin
                    done = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // All tasks start and end 2 time units after a rising edge.
    task automatic beat(input int i, input int f, input int a, input bit fi, input bit la,
                        input bit sp, input int pi);
        bit acc;
        in_valid = 1'b1;
        if_data = 8'(i); filt_data = 8'(f); entry_addr = AL'(a);
        first = fi; last = la; seed_psum = sp; psum_in = PW'(pi);
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready_w;
            @(posedge clk);
            #2;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat accept: got no in_ready, expected acceptance within 100 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int n0;
        bit acc;

        // Reset state
        @(negedge clk);
        chk("reset module_outval", 32'(module_outval_w), 32'd0);
        chk("reset outbuf_write", 32'(outbuf_write_w), 32'd0);
        chk("reset stall", 32'(stall_w), 32'd0);
        chk("reset in_ready", 32'(in_ready_w), 32'd1);
        chk("reset psum_done", 32'(psum_done_w), 32'd0);
        chk("reset overflow", 32'(overflow_w), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(1);

        // Single window on entry 1: 12 + 30 + 20 = 62
        n0 = log_w.size();
        beat(3, 4, 1, 1'b1, 1'b0, 1'b0, 0);
        beat(5, 6, 1, 1'b0, 1'b0, 1'b0, 0);
        beat(2, 10, 1, 1'b0, 1'b1, 1'b0, 0);
        idle(4);
        chk("window write count", 32'(log_w.size() - n0), 32'd1);
        chk("window value", 32'(log_w[$]), 32'd62);
        chk("window addr", 32'(log_a[$]), 32'd1);

        // Seeded window: 1000 + 100
        beat(10, 10, 0, 1'b1, 1'b1, 1'b1, 1000);
        idle(4);
        chk("seeded value", 32'(log_w[$]), 32'd1100);
        chk("seeded overflow", 32'(overflow_w), 32'd0);

        // Interleaved entries 0 and 2, back to back
        n0 = log_w.size();
        for (int i = 0; i < 4; i++) begin
            beat(1, 1, 0, i == 0, i == 3, 1'b0, 0);
            beat(1, 1, 2, i == 0, i == 3, 1'b0, 0);
        end
        idle(4);
        chk("interleave count", 32'(log_w.size() - n0), 32'd2);
        chk("interleave val0", 32'(log_w[n0]), 32'd4);
        chk("interleave addr0", 32'(log_a[n0]), 32'd0);
        chk("interleave val1", 32'(log_w[n0 + 1]), 32'd4);
        chk("interleave addr1", 32'(log_a[n0 + 1]), 32'd2);

        // Back-pressure: result 49 held while outbuf_full, beat C waits upstream
        n0 = log_w.size();
        outbuf_full = 1'b1;
        beat(7, 7, 1, 1'b1, 1'b1, 1'b0, 0);
        beat(1, 1, 1, 1'b1, 1'b1, 1'b0, 0);
        in_valid = 1'b1; if_data = 8'd2; filt_data = 8'd2; entry_addr = 2'd0;
        first = 1'b1; last = 1'b1; seed_psum = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp stall", 32'(stall_w), 32'd1);
            chk("bp in_ready", 32'(in_ready_w), 32'd0);
            chk("bp outval stable", 32'(module_outval_w), 32'd49);
        end
        @(posedge clk);
        #2;
        outbuf_full = 1'b0;
        @(negedge clk);
        chk("bp release write", 32'(outbuf_write_w), 32'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        idle(4);
        chk("bp count", 32'(log_w.size() - n0), 32'd3);
        chk("bp val0", 32'(log_w[n0]), 32'd49);
        chk("bp val1", 32'(log_w[n0 + 1]), 32'd1);
        chk("bp val2", 32'(log_w[n0 + 2]), 32'd4);

        // Overflow: 65500 + 255 -> wrap 219 / clamp 65535, sticky until clr
        beat(255, 1, 2, 1'b1, 1'b1, 1'b1, 65500);
        idle(4);
        chk("ovf wrap value", 32'(log_w[$]), 32'd219);
        chk("ovf sat value", 32'(log_s[$]), 32'd65535);
        chk("ovf flag wrap", 32'(overflow_w), 32'd1);
        chk("ovf flag sat", 32'(overflow_s), 32'd1);
        beat(1, 1, 0, 1'b1, 1'b1, 1'b0, 0);
        idle(3);
        chk("ovf sticky", 32'(overflow_w), 32'd1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        @(negedge clk);
        chk("ovf cleared", 32'(overflow_w), 32'd0);
        @(posedge clk);
        #2;

        // clr mid-window; the beat presented with clr is dropped
        n0 = log_w.size();
        beat(5, 5, 0, 1'b1, 1'b0, 1'b0, 0);
        beat(5, 5, 0, 1'b0, 1'b0, 1'b0, 0);
        clr = 1'b1;
        in_valid = 1'b1; if_data = 8'd9; filt_data = 8'd9; first = 1'b0; last = 1'b1;
        idle(1);
        clr = 1'b0;
        in_valid = 1'b0;
        beat(2, 3, 0, 1'b0, 1'b1, 1'b0, 0);
        idle(4);
        chk("clr count", 32'(log_w.size() - n0), 32'd1);
        chk("clr value", 32'(log_w[$]), 32'd6);

        // Entry persists after last: 6 + 2
        beat(1, 2, 0, 1'b0, 1'b1, 1'b0, 0);
        idle(4);
        chk("persist value", 32'(log_w[$]), 32'd8);

        // Out-of-range entry is discarded
        n0 = log_w.size();
        beat(3, 3, 3, 1'b1, 1'b1, 1'b0, 0);
        idle(4);
        chk("oor no write", 32'(log_w.size() - n0), 32'd0);

        // Randomized traffic with random back-pressure and occasional clr
        acc = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom % 5) != 0;
                if_data = 8'($urandom);
                filt_data = 8'($urandom);
                entry_addr = AL'($urandom_range(0, 3));
                first = ($urandom % 4) == 0;
                last = ($urandom % 3) == 0;
                seed_psum = $urandom % 2;
                psum_in = PW'($urandom);
            end
            outbuf_full = ($urandom % 4) == 0;
            clr = ($urandom % 60) == 0;
            @(negedge clk);
            acc = in_ready_w;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        clr = 1'b0;
        outbuf_full = 1'b0;
        idle(5);

        // Async reset pulse mid-cycle while a result is stalled
        outbuf_full = 1'b1;
        beat(4, 4, 1, 1'b1, 1'b1, 1'b0, 0);
        idle(3);
        #1;
        rst = 1'b1;
        rst_pulses++;
        #1;
        chk("async rst outval", 32'(module_outval_w), 32'd0);
        chk("async rst write", 32'(outbuf_write_w), 32'd0);
        chk("async rst stall", 32'(stall_w), 32'd0);
        chk("async rst in_ready", 32'(in_ready_w), 32'd1);
        chk("async rst overflow", 32'(overflow_s), 32'd0);
        rst = 1'b0;
        outbuf_full = 1'b0;
        idle(2);
        beat(6, 7, 2, 1'b1, 1'b1, 1'b0, 0);
        idle(4);
        chk("post rst value", 32'(log_w[$]), 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psum_accum_unit.md
Name: psum_accum_unit

Overview:
- Parametrised multi-filter MAC/partial-sum engine; successor of the single-channel PE multiply/accumulate datapath.
- Two-stage pipeline: multiply, then accumulate into one of FILT_NUM partial-sum registers selected per beat.
- Each entry can be seeded from zero or from an external psum, with optional saturation.
- Completed sums are written to the output buffer under an outbuf_full stall handshake.

Parameters:
- IF_WIDTH, 8, IF operand width (unsigned)
- FILT_WIDTH, 8, filter operand width (unsigned)
- PSUM_WIDTH, 20, partial-sum / result width; must be >= IF_WIDTH+FILT_WIDTH
- FILT_NUM, 4, number of partial-sum entries (concurrent filters)
- ADDR_LEN, 2, entry index width; FILT_NUM <= 2**ADDR_LEN
- SATURATE, 0, 1 = clamp at all-ones on overflow; 0 = wrap modulo 2**PSUM_WIDTH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of entries, pipeline, output and flags
- in_valid  in  1  operand beat present
- in_ready  out  1  beat accepted this cycle; equals ~stall_pipeline
- if_data  in  IF_WIDTH  IF operand
- filt_data  in  FILT_WIDTH  filter operand
- entry_addr  in  ADDR_LEN  target partial-sum entry
- first  in  1  first beat of a window; base is the seed, not the stored entry
- last  in  1  last beat of a window; emit result
- seed_psum  in  1  with first: seed = psum_in, else seed = 0
- psum_in  in  PSUM_WIDTH  external partial sum (sampled with the beat)
- outbuf_full  in  1  output buffer cannot accept
- outbuf_write  out  1  write strobe to output buffer
- module_outval  out  PSUM_WIDTH  result data
- out_addr  out  ADDR_LEN  entry index of result
- psum_done  out  1  one-cycle pulse when outbuf_write completes
- stall_pipeline  out  1  pipeline frozen
- overflow  out  1  sticky; set on any wrap or clamp

Behaviour:
- Reset (rst=1, async): all entries, stage registers, out_valid, module_outval, out_addr, overflow and psum_done go to 0. outbuf_write=0, stall_pipeline=0, in_ready=1.
- Beat acceptance: in_valid & in_ready.
- S1 (edge t of an accepted beat): latch prod = if_data*filt_data (IF_WIDTH+FILT_WIDTH bits, zero-extended to PSUM_WIDTH), plus addr, first, last, and seed (psum_in if seed_psum else 0). s1_valid <= 1; s1_valid <= 0 if no beat.
- S2 (edge t+1 when s1_valid): base = first ? seed : entry[addr]; sum = base + prod, computed at PSUM_WIDTH+1 bits.
  - If the carry is set: overflow <= 1; result = all-ones if SATURATE=1, else the low PSUM_WIDTH bits.
  - Write entry[addr] <= result.
  - If last: module_outval <= result, out_addr <= addr, out_valid <= 1.
- Back-to-back beats to the same entry need no bypass: the S2 write at edge t+1 is visible to the next beat's S2 at t+2. A bench must confirm this with no bubble.
- Output handshake:
  - outbuf_write = out_valid & ~outbuf_full, combinational.
  - On the edge where outbuf_write=1: out_valid <= 0 (unless a new last loads in the same edge, which sets it to 1), and psum_done <= 1 for one cycle.
  - Latency from accepted last beat at edge t: outbuf_write is high in the cycle after edge t+1, given outbuf_full=0.
- Stall:
  - stall_pipeline = out_valid & outbuf_full.
  - While stalled: S1/S2 registers, entries and overflow hold; no beat is accepted; module_outval/out_addr are held stable.
  - Upstream must hold its beat until in_ready.
- Entries are not cleared after last. A later non-first beat continues from the stored value.
- clr (sync, priority over everything except rst):
  - Next edge: all entries = 0, s1_valid = 0, out_valid = 0, overflow = 0, psum_done = 0.
  - Any beat presented in the clr cycle is dropped.
- entry_addr >= FILT_NUM: the beat is discarded in S2 (no write, no output), and overflow is unaffected.
- psum_in, first and seed_psum are sampled only on acceptance.

Test Plan:
- Single window, entry 1: beats (3,4,first),(5,6),(2,10,last) -> one outbuf_write, module_outval=62, out_addr=1, psum_done pulse one cycle later.
- Seeded window: first+seed_psum, psum_in=1000, beat (10,10,first,last) -> module_outval=1100; overflow=0.
- Interleaved filters: alternate entries 0/2 every cycle, 4 beats each of (1,1) then a last on each -> results 4 (addr 0) and 4 (addr 2), emitted in order, with no stall and no bubble.
- Back-pressure: outbuf_full=1 for 5 cycles while a result is pending -> stall_pipeline=1, in_ready=0, module_outval stable. On release: outbuf_write the same cycle, and the pending S1 beat completes next.
- Overflow: PSUM_WIDTH=16, entry seeded 65500, add 255*1 -> SATURATE=0 gives 219; SATURATE=1 gives 65535; overflow=1 sticky until clr.
- clr/rst mid-window: clr after 2 beats, then non-first beat (2,3,last) -> 6. Async rst pulse mid-cycle -> outputs 0 immediately.
